// File: rtl/sram_mem_controller_if.sv
// Bundle between the MEM stage, the SRAM controller and the SRAM pins.
// master = pipeline/SRAM side, slave = controller.
interface sram_mem_controller_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_we_n;

    modport master (
        output mem_read, mem_write, address, wdata, sram_dq_i,
        input  rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  mem_read, mem_write, address, wdata, sram_dq_i,
        output rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_controller.sv
// MEM-stage to 16-bit async SRAM sequencer: each 32-bit word is two halves.
// Optional macro SRAM_LASTREAD_EN: last-load tag lets repeat loads skip the SRAM.
module sram_mem_controller #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_BASE   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_mem_controller_if.slave bus
);
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic          r_op_wr;
    logic [31:0]   r_waddr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [17:0]   r_saddr;
    logic [15:0]   r_dq_o;
    logic          r_oe;
    logic          r_we_n;

    logic          w_req;
    logic [31:0]   w_waddr;
    logic          w_last;
    logic          w_hit;
    logic          w_accept;
    logic          w_lo_end;
    logic          w_hi_end;
    logic          w_unused;

    assign w_req    = bus.mem_read | bus.mem_write;
    assign w_waddr  = (bus.address - ADDR_BASE) >> 2;
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_accept = (r_state == S_IDLE) & w_req & ~w_hit;
    assign w_lo_end = (r_state == S_LO) & w_last;
    assign w_hi_end = (r_state == S_HI) & w_last;
    assign w_unused = ^{w_waddr[31:17], r_waddr[31:17]};

`ifdef SRAM_LASTREAD_EN
    logic [31:0] r_tag;
    logic        r_tag_vld;

    assign w_hit = bus.mem_read & ~bus.mem_write & r_tag_vld
                 & (r_tag == w_waddr);

    // Remember the word of the last completed load; any store forgets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag     <= '0;
            r_tag_vld <= 1'b0;
        end else if ((r_state == S_IDLE) && bus.mem_write) begin
            r_tag_vld <= 1'b0;
        end else if (w_hi_end && !r_op_wr) begin
            r_tag     <= r_waddr;
            r_tag_vld <= 1'b1;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // State and half-cycle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: two halves of WAIT_CYCLES each, then one DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_req) begin
                    w_state_nxt = w_hit ? S_DONE : S_LO;
                end
            end
            S_LO: begin
                if (w_last) begin
                    w_state_nxt = S_HI;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HI: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Latch the request and drive SRAM pins from registers, one step ahead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_wr <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_saddr <= '0;
            r_dq_o  <= '0;
            r_oe    <= 1'b0;
            r_we_n  <= 1'b1;
        end else if (w_accept) begin
            r_op_wr <= bus.mem_write;
            r_waddr <= w_waddr;
            r_wdata <= bus.wdata;
            r_saddr <= {w_waddr[16:0], 1'b0};
            r_dq_o  <= bus.wdata[15:0];
            r_oe    <= bus.mem_write;
            r_we_n  <= ~bus.mem_write;
        end else if (w_lo_end) begin
            r_saddr <= {r_waddr[16:0], 1'b1};
            r_dq_o  <= r_wdata[31:16];
            if (!r_op_wr) begin
                r_rdata[15:0] <= bus.sram_dq_i;
            end
        end else if (w_hi_end) begin
            r_oe   <= 1'b0;
            r_we_n <= 1'b1;
            if (!r_op_wr) begin
                r_rdata[31:16] <= bus.sram_dq_i;
            end
        end
    end

    assign bus.ready = ((r_state == S_IDLE) && !w_req)
                     || (r_state == S_DONE);
    assign bus.rdata      = r_rdata;
    assign bus.sram_addr  = r_saddr;
    assign bus.sram_dq_o  = r_dq_o;
    assign bus.sram_dq_oe = r_oe;
    assign bus.sram_we_n  = r_we_n;
endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller (WAIT_CYCLES=2, ADDR_BASE=1024).
// SRAM is a small behavioural array indexed by sram_addr[5:0].
`timescale 1ns/1ps
module tb_sram_mem_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_mem_controller_if bus();

    sram_mem_controller #(
        .WAIT_CYCLES(2),
        .ADDR_BASE(1024)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

`ifdef SRAM_LASTREAD_EN
    localparam bit LR = 1'b1;
`else
    localparam bit LR = 1'b0;
`endif

    logic [15:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_a;
    logic [15:0] pl_d;

    always @(posedge clk) begin
        if (!bus.sram_we_n) mem[bus.sram_addr[5:0]] <= bus.sram_dq_o;
        else if (pl_en) mem[pl_a] <= pl_d;
    end

    assign bus.sram_dq_i = mem[bus.sram_addr[5:0]];

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ready;
        logic        exp_we_n;
        logic        exp_oe;
        logic [17:0] exp_sa;
        logic [15:0] exp_dq;
    } vec_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        hit;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [17:0] sa_miss;
        logic [17:0] sa_hit;
    } acc_t;

    vec_t trace [7];
    acc_t tbl [11];

    task automatic run_access(input acc_t a, input string name);
        int          cyc;
        int          we_low;
        int          exp_lat;
        logic [17:0] sa1;
        logic [31:0] rd_rdy;
        bit          done;
        bit          hit;
        @(posedge clk); #1;
        bus.mem_read  = a.rd;
        bus.mem_write = a.wr;
        bus.address   = a.addr;
        bus.wdata     = a.wdata;
        cyc = 0; we_low = 0; sa1 = 'x; rd_rdy = 'x; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (cyc == 1) sa1 = bus.sram_addr;
            if (!bus.sram_we_n) we_low++;
            if (bus.ready) begin
                done   = 1'b1;
                rd_rdy = bus.rdata;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        hit     = a.hit && LR;
        exp_lat = hit ? 1 : 5;
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " sram_addr"}, 64'(sa1),
              64'(hit ? a.sa_hit : a.sa_miss));
        check({name, " we_n low cycles"}, 64'(we_low), 64'(a.wr ? 4 : 0));
        check({name, " rdata"}, 64'(rd_rdy), 64'(a.exp_rdata));
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    initial begin
        trace[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF,
                     1'b0, 1'b1, 1'b0, 18'h0, 16'h0};
        trace[1] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF,
                     1'b0, 1'b0, 1'b1, 18'h0, 16'hBEEF};
        trace[2] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF,
                     1'b0, 1'b0, 1'b1, 18'h0, 16'hBEEF};
        trace[3] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF,
                     1'b0, 1'b0, 1'b1, 18'h1, 16'hDEAD};
        trace[4] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF,
                     1'b0, 1'b0, 1'b1, 18'h1, 16'hDEAD};
        trace[5] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF,
                     1'b1, 1'b1, 1'b0, 18'h1, 16'h0};
        trace[6] = '{1'b0, 1'b0, 32'd0, 32'h0,
                     1'b1, 1'b1, 1'b0, 18'h1, 16'h0};

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'd1028, 32'h0,
                    32'h56781234, 18'h2, 18'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D,
                    32'h56781234, 18'h4, 18'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'd1032, 32'h0,
                    32'hCAFEF00D, 18'h4, 18'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'd1024, 32'h11112222,
                    32'hCAFEF00D, 18'h0, 18'h0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'd1024, 32'h0,
                    32'h11112222, 18'h0, 18'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'd0, 32'h0,
                    32'h11112222, 18'h3FE00, 18'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'd0, 32'h0,
                    32'h11112222, 18'h3FE00, 18'h3FE01};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'd1028, 32'h0,
                    32'h56781234, 18'h2, 18'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'd1028, 32'h0,
                    32'h56781234, 18'h2, 18'h3};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'd1028, 32'h0BADC0DE,
                    32'h56781234, 18'h2, 18'h0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'd1028, 32'h0,
                    32'h0BADC0DE, 18'h2, 18'h0};

        rst_n = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.address = '0; bus.wdata = '0;
        pl_en = 1'b0; pl_a = '0; pl_d = '0;
        #12;
        check("reset ready", 64'(bus.ready), 64'h1);
        check("reset we_n", 64'(bus.sram_we_n), 64'h1);
        check("reset oe", 64'(bus.sram_dq_oe), 64'h0);
        check("reset rdata", 64'(bus.rdata), 64'h0);
        check("reset sram_addr", 64'(bus.sram_addr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            bus.mem_read  = trace[i].rd;
            bus.mem_write = trace[i].wr;
            bus.address   = trace[i].addr;
            bus.wdata     = trace[i].wdata;
            @(negedge clk);
            check($sformatf("store trace c%0d", i),
                  64'({bus.ready, bus.sram_we_n, bus.sram_dq_oe,
                       bus.sram_addr,
                       bus.sram_dq_o & {16{trace[i].exp_oe}}}),
                  64'({trace[i].exp_ready, trace[i].exp_we_n,
                       trace[i].exp_oe, trace[i].exp_sa,
                       trace[i].exp_dq}));
        end
        check("sram word0 lo", 64'(mem[0]), 64'hBEEF);
        check("sram word0 hi", 64'(mem[1]), 64'hDEAD);

        preload(6'd2, 16'h1234);
        preload(6'd3, 16'h5678);

        for (int i = 0; i < 11; i++) begin
            run_access(tbl[i], $sformatf("acc%0d", i));
        end
        @(posedge clk); #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rdata held", 64'(bus.rdata), 64'h0BADC0DE);
        check("idle ready", 64'(bus.ready), 64'h1);

        @(posedge clk); #1;
        bus.mem_write = 1'b1; bus.address = 32'd1104;
        bus.wdata = 32'h12345678;
        repeat (3) @(posedge clk);
        #2;
        check("mid HI we_n", 64'(bus.sram_we_n), 64'h0);
        check("mid HI sram_addr", 64'(bus.sram_addr), 64'h29);
        bus.mem_write = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort we_n", 64'(bus.sram_we_n), 64'h1);
        check("abort oe", 64'(bus.sram_dq_oe), 64'h0);
        check("abort ready", 64'(bus.ready), 64'h1);
        check("abort rdata", 64'(bus.rdata), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_access('{1'b1, 1'b0, 1'b0, 32'd1028, 32'h0,
                     32'h0BADC0DE, 18'h2, 18'h0}, "post-reset load");
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
